// File: rtl/manejador_alu_v2_if.sv
// Board-side bus of the pushbutton ALU manager: raw buttons and switches in,
// registered result, flags and status out.
interface manejador_alu_v2_if #(
    parameter int NBITS = 8
);
    // No ready/valid handshake on the input side: buttons are raw, asynchronous levels.
    // On the output side, result_valid is a one-cycle pulse with no back-pressure,
    // and dato_R/flags hold their value until the next valid execution.
    logic [2:0]       p_abc;
    logic [NBITS-1:0] buf_in;
    logic [NBITS-1:0] dato_R;
    logic [3:0]       flags;
    logic             result_valid;
    logic             busy;
    logic             op_err;
    logic             fsm_state;

    modport master (
        output p_abc, buf_in,
        input  dato_R, flags, result_valid, busy, op_err, fsm_state
    );

    modport slave (
        input  p_abc, buf_in,
        output dato_R, flags, result_valid, busy, op_err, fsm_state
    );
endinterface

// File: rtl/manejador_alu_v2.sv
// Pushbutton-driven ALU manager: synchronised, debounced buttons load A, B and the
// opcode from one switch bus; the result is registered with flags and a valid pulse.
module manejador_alu_v2 #(
    parameter int NBITS      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    manejador_alu_v2_if.slave   bus
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [NBITS-1:0] NB_L    = NBITS'(NBITS);
    localparam int M = NBITS - 1;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SLL = 6'b000000;

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_next;

    logic [2:0]       sync1, btn_s, btn_db, btn_db_q, press;
    logic [CW-1:0]    cnt [3];
    logic [NBITS-1:0] a, b, dato_r;
    logic [5:0]       opcode;
    logic [3:0]       flags_r;
    logic             result_valid_r, op_err_r;

    logic [NBITS-1:0] res;
    logic [NBITS:0]   sh;
    logic             c, v, op_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            btn_s    <= '0;
            btn_db_q <= '0;
        end else begin
            sync1    <= bus.p_abc;
            btn_s    <= sync1;
            btn_db_q <= btn_db;
        end
    end

    // A level change is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_s[i] == btn_db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    btn_db[i] <= btn_s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press[0]) state_next = EXEC;
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shifts run on a one-bit-wider word so the last bit shifted out lands in sh.
    always_comb begin
        res   = '0;
        sh    = '0;
        c     = 1'b0;
        v     = 1'b0;
        op_ok = 1'b1;
        case (opcode)
            OP_ADD: begin
                {c, res} = {1'b0, a} + {1'b0, b};
                v = (a[M] == b[M]) && (res[M] != a[M]);
            end
            OP_SUB: begin
                res = a - b;
                c   = (a < b);
                v   = (a[M] != b[M]) && (res[M] != a[M]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_SRL: begin
                if (b < NB_L) begin
                    sh  = {a, 1'b0} >> b;
                    res = sh[NBITS:1];
                    c   = sh[0];
                end
            end
            OP_SRA: begin
                if (b < NB_L) begin
                    sh  = $unsigned($signed({a, 1'b0}) >>> b);
                    res = sh[NBITS:1];
                    c   = sh[0];
                end else begin
                    res = {NBITS{a[M]}};
                    c   = a[M];
                end
            end
            OP_SLL: begin
                if (b < NB_L) begin
                    sh  = {1'b0, a} << b;
                    res = sh[NBITS-1:0];
                    c   = sh[NBITS];
                end
            end
            default: op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a              <= '0;
            b              <= '0;
            opcode         <= '0;
            dato_r         <= '0;
            flags_r        <= '0;
            result_valid_r <= 1'b0;
            op_err_r       <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            if (press[2]) a <= bus.buf_in;
            if (press[1]) b <= bus.buf_in;
            if (state == IDLE && press[0]) opcode <= bus.buf_in[5:0];
            if (state == EXEC) begin
                if (op_ok) begin
                    dato_r         <= res;
                    flags_r        <= {res[M], (res == '0), c, v};
                    result_valid_r <= 1'b1;
                    op_err_r       <= 1'b0;
                end else begin
                    op_err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.dato_R       = dato_r;
    assign bus.flags        = flags_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = (state == EXEC);
    assign bus.op_err       = op_err_r;
    assign bus.fsm_state    = (state == EXEC);
endmodule

// File: tb/tb_manejador_alu_v2.sv
// Bench for manejador_alu_v2: table of ALU vectors plus hand-written debounce,
// invalid-opcode, reset and simultaneous-press sequences.
module tb_manejador_alu_v2;
    localparam int NB  = 8;
    localparam int DEB = 4;
    localparam int LAT = DEB + 4;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SLL = 6'b000000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [5:0]    op;
        logic [NB-1:0] d;
        logic [3:0]    f;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    manejador_alu_v2_if #(.NBITS(NB)) bus_if ();

    manejador_alu_v2 #(.NBITS(NB), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int vectors        = 0;
    int miscompares    = 0;
    int pulse_cnt      = 0;
    int busy_cnt       = 0;
    int last_pulse_cyc = 0;
    int press_cyc      = 0;
    logic [NB+3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every result pulse is matched against the oldest expectation.
    initial begin : monitor
        logic [NB+3:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.busy) busy_cnt++;
                if (bus_if.result_valid) begin
                    pulse_cnt++;
                    last_pulse_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dato_R", 32'(bus_if.dato_R), 32'(e[NB-1:0]));
                        check("flags", 32'(bus_if.flags), 32'(e[NB+3:NB]));
                    end
                end
            end
        end
    end

    task automatic press(input logic [2:0] m, input logic [NB-1:0] val, input int hold);
        bus_if.buf_in = val;
        bus_if.p_abc  = m;
        press_cyc     = cyc;
        repeat (hold) @(negedge clk);
        bus_if.p_abc = 3'b000;
        repeat (14) @(negedge clk);
    endtask

    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [5:0] op,
                          input logic [NB-1:0] d, input logic [3:0] f);
        int p0;
        press(3'b100, a, DEB);
        press(3'b010, b, DEB);
        p0 = pulse_cnt;
        exp_q.push_back({f, d});
        press(3'b001, NB'(op), DEB);
        check("pulse_count", 32'(pulse_cnt - p0), 32'd1);
        check("op_err_clear", 32'(bus_if.op_err), 32'd0);
    endtask

    vec_t vt [21];

    initial begin
        int p0, b0, lat1;
        logic found;

        vt[0]  = '{8'd20, 8'd7,  OP_ADD, 8'd27, 4'b0000};
        vt[1]  = '{8'd20, 8'd7,  OP_SUB, 8'd13, 4'b0000};
        vt[2]  = '{8'd7,  8'd20, OP_SUB, 8'hF3, 4'b1010};
        vt[3]  = '{8'h7F, 8'h01, OP_ADD, 8'h80, 4'b1001};
        vt[4]  = '{8'hFF, 8'h01, OP_ADD, 8'h00, 4'b0110};
        vt[5]  = '{8'h60, 8'h02, OP_SRL, 8'h18, 4'b0000};
        vt[6]  = '{8'h60, 8'h02, OP_SRA, 8'h18, 4'b0000};
        vt[7]  = '{8'hE0, 8'h02, OP_SRL, 8'h38, 4'b0000};
        vt[8]  = '{8'hE0, 8'h02, OP_SRA, 8'hF8, 4'b1000};
        vt[9]  = '{8'hE0, 8'h09, OP_SRA, 8'hFF, 4'b1010};
        vt[10] = '{8'hE0, 8'h09, OP_SRL, 8'h00, 4'b0100};
        vt[11] = '{8'h81, 8'h01, OP_SLL, 8'h02, 4'b0010};
        vt[12] = '{8'hF0, 8'h3C, OP_AND, 8'h30, 4'b0000};
        vt[13] = '{8'hF0, 8'h3C, OP_OR,  8'hFC, 4'b1000};
        vt[14] = '{8'hF0, 8'h3C, OP_XOR, 8'hCC, 4'b1000};
        vt[15] = '{8'hF0, 8'h3C, OP_NOR, 8'h03, 4'b0000};
        vt[16] = '{8'h81, 8'h00, OP_SLL, 8'h81, 4'b1000};
        vt[17] = '{8'h80, 8'h08, OP_SRA, 8'hFF, 4'b1010};
        vt[18] = '{8'hFF, 8'h08, OP_SLL, 8'h00, 4'b0100};
        vt[19] = '{8'h05, 8'h05, OP_SUB, 8'h00, 4'b0100};
        vt[20] = '{8'h80, 8'h01, OP_SUB, 8'h7F, 4'b0001};

        bus_if.p_abc  = 3'b000;
        bus_if.buf_in = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dato_R", 32'(bus_if.dato_R), 32'd0);
        check("rst_flags", 32'(bus_if.flags), 32'd0);
        check("rst_valid", 32'(bus_if.result_valid), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_op_err", 32'(bus_if.op_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 21; i++)
            run_op(vt[i].a, vt[i].b, vt[i].op, vt[i].d, vt[i].f);

        // Debounce: A=20, B=7 loaded, repeated ADD presses of different lengths.
        run_op(8'd20, 8'd7, OP_ADD, 8'd27, 4'b0000);
        p0 = pulse_cnt; b0 = busy_cnt;
        press(3'b001, NB'(OP_ADD), DEB - 1);
        check("short_press_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("short_press_busy", 32'(busy_cnt - b0), 32'd0);

        p0 = pulse_cnt; b0 = busy_cnt;
        exp_q.push_back({4'b0000, 8'd27});
        press(3'b001, NB'(OP_ADD), DEB);
        lat1 = last_pulse_cyc - press_cyc;
        check("exact_press_pulse", 32'(pulse_cnt - p0), 32'd1);
        check("exact_press_busy", 32'(busy_cnt - b0), 32'd1);
        check("latency", 32'(lat1), 32'(LAT));

        p0 = pulse_cnt; b0 = busy_cnt;
        exp_q.push_back({4'b0000, 8'd27});
        press(3'b001, NB'(OP_ADD), 200);
        check("long_press_pulse", 32'(pulse_cnt - p0), 32'd1);
        check("long_press_busy", 32'(busy_cnt - b0), 32'd1);
        check("latency_repeat", 32'(last_pulse_cyc - press_cyc), 32'(lat1));

        // Invalid opcode keeps the result, sets op_err; the next valid op clears it.
        p0 = pulse_cnt;
        press(3'b001, NB'(OP_BAD), DEB);
        check("bad_op_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("bad_op_err", 32'(bus_if.op_err), 32'd1);
        check("bad_op_dato", 32'(bus_if.dato_R), 32'd27);
        check("bad_op_flags", 32'(bus_if.flags), 32'd0);
        p0 = pulse_cnt;
        exp_q.push_back({4'b0000, 8'h04});
        press(3'b001, NB'(OP_AND), DEB);
        check("and_after_bad_pulse", 32'(pulse_cnt - p0), 32'd1);
        check("and_after_bad_err", 32'(bus_if.op_err), 32'd0);

        // Reset while busy aborts the operation.
        run_op(8'hF0, 8'h3C, OP_OR, 8'hFC, 4'b1000);
        bus_if.buf_in = NB'(OP_ADD);
        bus_if.p_abc  = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus_if.busy) found = 1'b1;
        end
        check("busy_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midexec_rst_dato", 32'(bus_if.dato_R), 32'd0);
        check("midexec_rst_flags", 32'(bus_if.flags), 32'd0);
        check("midexec_rst_valid", 32'(bus_if.result_valid), 32'd0);
        check("midexec_rst_busy", 32'(bus_if.busy), 32'd0);
        check("midexec_rst_err", 32'(bus_if.op_err), 32'd0);
        bus_if.p_abc = 3'b000;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulse_cnt;
        repeat (20) @(negedge clk);
        check("no_pulse_after_rst", 32'(pulse_cnt - p0), 32'd0);

        // A and opcode pressed together: the freshly loaded A (0x20) is used.
        run_op(8'h10, 8'h03, OP_ADD, 8'h13, 4'b0000);
        p0 = pulse_cnt;
        exp_q.push_back({4'b0000, 8'h23});
        press(3'b101, 8'h20, DEB);
        check("simul_pulse", 32'(pulse_cnt - p0), 32'd1);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
